axis_256to512_packer: RTL
=========================

Name: axis_256to512_packer

Overview:
- AXI4-Stream width up-converter: packs pairs of 256-bit input beats into one 512-bit output beat.
- Sits on the return path opposite the 512-to-256 down-converter, restoring full-width beats ahead of the 512-bit datapath.
- Packet boundaries (TLAST) and byte enables (TKEEP) are preserved.
- Odd-length packets emit a half-filled final beat.

Parameters:
- C_WIDTH_TDATA, 256, input data width; output width is 2*C_WIDTH_TDATA.
- C_WIDTH_TKEEP, C_WIDTH_TDATA/8, input keep width; output keep width is 2*C_WIDTH_TKEEP.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous reset, active-low (asserted at 0).
- in_TVALID  input  1  input beat valid.
- in_TREADY  output  1  input beat accepted when high with in_TVALID.
- in_TDATA  input  C_WIDTH_TDATA  input data, byte 0 in bits [7:0].
- in_TKEEP  input  C_WIDTH_TKEEP  input byte enables.
- in_TLAST  input  1  last beat of packet.
- out_TVALID  output  1  output beat valid.
- out_TREADY  input  1  downstream ready.
- out_TDATA  output  2*C_WIDTH_TDATA  packed data.
- out_TKEEP  output  2*C_WIDTH_TKEEP  packed byte enables.
- out_TLAST  output  1  last beat of packet.

Behaviour:
- Reset (rst=0, asynchronous):
  - out_TVALID=0, out_TDATA=0, out_TKEEP=0, out_TLAST=0.
  - Low-half buffer cleared; FSM to S_LO.
  - Takes effect mid-packet; any partial beat is discarded.
  - First beat after reset release is treated as a low half.
- Definitions:
  - in_fire = in_TVALID & in_TREADY.
  - out_fire = out_TVALID & out_TREADY.
  - out_free = !out_TVALID | out_TREADY.
- in_TREADY = out_free when not in reset; 0 during reset.
- FSM states:
  - S_LO: waiting for the low half.
  - S_HI: low half held in lo_data/lo_keep, waiting for the high half.
- S_LO, in_fire, in_TLAST=0:
  - Store in_TDATA/in_TKEEP into the low buffer; go to S_HI; no output.
- S_LO, in_fire, in_TLAST=1 (odd packet end):
  - Next cycle out_TDATA = {0, in_TDATA}, out_TKEEP = {0, in_TKEEP}, out_TLAST=1, out_TVALID=1.
  - Stay in S_LO.
- S_HI, in_fire:
  - Next cycle out_TDATA = {in_TDATA, lo_data}, out_TKEEP = {in_TKEEP, lo_keep}, out_TLAST = in_TLAST, out_TVALID=1.
  - Go to S_LO.
- Output register:
  - Holds value and out_TVALID until out_fire. Output fields stay stable while out_TVALID=1 & out_TREADY=0.
  - If out_fire occurs with no new load: out_TVALID clears next cycle.
  - If out_fire and a load occur in the same cycle: the new beat replaces the old one back-to-back; out_TVALID stays 1.
- Latency: 1 cycle from the accepting edge of a high half (or odd last beat) to out_TVALID.
- Throughput:
  - One input beat per cycle while the output is not stalled.
  - One output beat per two input beats.
- in_TVALID low in S_HI: low half held indefinitely; no timeout.
- TKEEP is passed through unchecked; non-contiguous keep is not corrected.
- out_TDATA upper half is forced to 0 on odd-end beats (not stale data).

Optional Feature:
- Macro: AXIS_UPCONV_SKID_EN.
- Defined:
  - Two-entry skid buffer on the input side.
  - in_TREADY is a registered signal, high when the skid has at least one free entry; this breaks the combinational out_TREADY-to-in_TREADY path.
  - Skid entries are drained into the packer in order; latency becomes 2 cycles when the skid is empty on entry.
  - Full throughput is retained.
  - Skid is cleared on reset.
- Undefined:
  - in_TREADY is combinational from out_TREADY as above; latency is 1 cycle.

Test Plan:
- Two-beat packet, out_TREADY=1:
  - Stimulus: beat0 data=256'hA..A keep=all-1 last=0; beat1 data=256'hB..B keep=32'h0000FFFF last=1.
  - Response: one output beat {B..B, A..A}, keep=64'h0000FFFF_FFFFFFFF, last=1, one cycle after beat1.
- Odd packet, 3 beats C, D, E (E last, keep=32'hF):
  - Response: output beat {D,C} keep=all-1 last=0, then {0,E} keep=64'h0000000F last=1.
- Back-pressure:
  - Stimulus: out_TREADY=0 for 5 cycles while streaming.
  - Response: in_TREADY falls within the same cycle (1 cycle later with AXIS_UPCONV_SKID_EN); out_* stable; no beat lost or duplicated; order preserved after release.
- Continuous stream:
  - Stimulus: 8 input beats with in_TVALID held high and out_TREADY=1.
  - Response: 4 output beats on alternate cycles; in_TREADY never drops.
- Reset mid-packet:
  - Stimulus: assert rst=0 while in S_HI with low half F held; release; send packet G, H (H last).
  - Response: out_TVALID=0 immediately on reset; F never emitted; next output {H,G} last=1.
- Idle gaps:
  - Stimulus: insert in_TVALID=0 for 3 cycles between low and high halves.
  - Response: correct packed output; no spurious out_TVALID during the gap.

Source files
------------

// File: rtl/axis_256to512_packer.sv
// AXI4-Stream 256-to-512 width up-converter: pairs of input beats become one output beat.
// Define AXIS_UPCONV_SKID_EN to insert a two-entry input skid buffer with a registered in_TREADY.
module axis_256to512_packer #(
    parameter int C_WIDTH_TDATA = 256,
    parameter int C_WIDTH_TKEEP = C_WIDTH_TDATA / 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_TVALID,
    output logic                       in_TREADY,
    input  logic [C_WIDTH_TDATA-1:0]   in_TDATA,
    input  logic [C_WIDTH_TKEEP-1:0]   in_TKEEP,
    input  logic                       in_TLAST,
    output logic                       out_TVALID,
    input  logic                       out_TREADY,
    output logic [2*C_WIDTH_TDATA-1:0] out_TDATA,
    output logic [2*C_WIDTH_TKEEP-1:0] out_TKEEP,
    output logic                       out_TLAST
);

    typedef enum logic {S_LO, S_HI} state_t;

    state_t                     state_q, state_d;
    logic [C_WIDTH_TDATA-1:0]   lo_data_q, lo_data_d;
    logic [C_WIDTH_TKEEP-1:0]   lo_keep_q, lo_keep_d;
    logic                       out_valid_q, out_valid_d;
    logic [2*C_WIDTH_TDATA-1:0] out_data_q, out_data_d;
    logic [2*C_WIDTH_TKEEP-1:0] out_keep_q, out_keep_d;
    logic                       out_last_q, out_last_d;

    // Packer-side beat source: either the raw input or the skid head.
    logic                       pk_valid;
    logic [C_WIDTH_TDATA-1:0]   pk_data;
    logic [C_WIDTH_TKEEP-1:0]   pk_keep;
    logic                       pk_last;
    logic                       pk_fire;
    logic                       out_free;
    logic                       out_fire;

    assign out_free = !out_valid_q || out_TREADY;
    assign out_fire = out_valid_q && out_TREADY;
    assign pk_fire  = pk_valid && out_free;

`ifdef AXIS_UPCONV_SKID_EN
    logic [C_WIDTH_TDATA-1:0] skid_data_q [2];
    logic [C_WIDTH_TKEEP-1:0] skid_keep_q [2];
    logic                     skid_last_q [2];
    logic                     wr_ptr_q, wr_ptr_d;
    logic                     rd_ptr_q, rd_ptr_d;
    logic [1:0]               cnt_q, cnt_d;
    logic                     in_tready_q, in_tready_d;
    logic                     push;

    assign push      = in_TVALID && in_tready_q;
    assign in_TREADY = in_tready_q;
    assign pk_valid  = (cnt_q != 2'd0);
    assign pk_data   = skid_data_q[rd_ptr_q];
    assign pk_keep   = skid_keep_q[rd_ptr_q];
    assign pk_last   = skid_last_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d    = wr_ptr_q ^ push;
        rd_ptr_d    = rd_ptr_q ^ pk_fire;
        cnt_d       = cnt_q + {1'b0, push} - {1'b0, pk_fire};
        // Ready looks at next occupancy so a push is never offered into a full skid.
        in_tready_d = (cnt_d != 2'd2);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
            in_tready_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                skid_data_q[i] <= '0;
                skid_keep_q[i] <= '0;
                skid_last_q[i] <= 1'b0;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            in_tready_q <= in_tready_d;
            if (push) begin
                skid_data_q[wr_ptr_q] <= in_TDATA;
                skid_keep_q[wr_ptr_q] <= in_TKEEP;
                skid_last_q[wr_ptr_q] <= in_TLAST;
            end
        end
    end
`else
    assign in_TREADY = rst && out_free;
    assign pk_valid  = in_TVALID;
    assign pk_data   = in_TDATA;
    assign pk_keep   = in_TKEEP;
    assign pk_last   = in_TLAST;
`endif

    always_comb begin
        state_d     = state_q;
        lo_data_d   = lo_data_q;
        lo_keep_d   = lo_keep_q;
        out_valid_d = out_fire ? 1'b0 : out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        if (pk_fire) begin
            case (state_q)
                S_LO: begin
                    if (pk_last) begin
                        // Odd packet end: upper half zeroed rather than left stale.
                        out_valid_d = 1'b1;
                        out_data_d  = {{C_WIDTH_TDATA{1'b0}}, pk_data};
                        out_keep_d  = {{C_WIDTH_TKEEP{1'b0}}, pk_keep};
                        out_last_d  = 1'b1;
                    end else begin
                        lo_data_d = pk_data;
                        lo_keep_d = pk_keep;
                        state_d   = S_HI;
                    end
                end
                default: begin
                    out_valid_d = 1'b1;
                    out_data_d  = {pk_data, lo_data_q};
                    out_keep_d  = {pk_keep, lo_keep_q};
                    out_last_d  = pk_last;
                    state_d     = S_LO;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_LO;
            lo_data_q   <= '0;
            lo_keep_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lo_data_q   <= lo_data_d;
            lo_keep_q   <= lo_keep_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_TVALID = out_valid_q;
    assign out_TDATA  = out_data_q;
    assign out_TKEEP  = out_keep_q;
    assign out_TLAST  = out_last_q;

endmodule
